model_streamer: RTL and testbench

Triangle producer feeding the write side of the graphics triangle FIFO. On `start_in` it walks a contiguous block of triangle records in a synchronous 128-bit model ROM. For each record it emits one `vertex_valid_out` pulse carrying the vertex word and one `material_valid_out` pulse carrying the material word. The FIFO has no overflow protection, so this block owns flow control: it keeps a credit count of unconsumed entries and never exceeds FIFO capacity.

---
 rtl/model_streamer_if.sv | 43 ++++
 rtl/model_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_model_streamer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_streamer_if.sv
// Bundle of the start/ROM/FIFO-write signals of model_streamer.
// The abort_in line exists only when STREAMER_ABORT_EN is defined.
interface model_streamer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  start_in;
    logic [ADDR_WIDTH-1:0] base_addr_in;
    logic [15:0]           tri_count_in;
    logic                  consumed_in;
`ifdef STREAMER_ABORT_EN
    logic                  abort_in;
`endif
    logic [ADDR_WIDTH-1:0] rom_addr_out;
    logic [127:0]          rom_data_in;
    logic                  vertex_valid_out;
    logic [3:0][31:0]      vertex_out;
    logic                  material_valid_out;
    logic [11:0]           material_out;
    logic                  busy_out;
    logic                  done_out;
    logic                  error_out;
    logic [2:0]            dbg_state;

    // Streamer side: drives the ROM address and the FIFO write strobes.
    modport master (
`ifdef STREAMER_ABORT_EN
        input  abort_in,
`endif
        input  start_in, base_addr_in, tri_count_in, consumed_in, rom_data_in,
        output rom_addr_out, vertex_valid_out, vertex_out, material_valid_out,
        output material_out, busy_out, done_out, error_out, dbg_state
    );

    // Environment side: control, ROM data and FIFO consumption feedback.
    modport slave (
`ifdef STREAMER_ABORT_EN
        output abort_in,
`endif
        output start_in, base_addr_in, tri_count_in, consumed_in, rom_data_in,
        input  rom_addr_out, vertex_valid_out, vertex_out, material_valid_out,
        input  material_out, busy_out, done_out, error_out, dbg_state
    );
endinterface

// File: rtl/model_streamer.sv
// Walks triangle records in a model ROM and writes vertex/material pairs into the
// triangle FIFO under credit control. Define STREAMER_ABORT_EN to add abort_in.
module model_streamer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic             clk_in,
    input  logic             rst_in,
    model_streamer_if.master bus
);
    localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int CRED_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
    localparam logic [CRED_W-1:0]     CRED_MAX  = CRED_W'(FIFO_DEPTH - 1);
    localparam logic [CRED_W-1:0]     CRED_ONE  = CRED_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = ADDR_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRECHECK = 3'd1,
        S_REQ_V    = 3'd2,
        S_WAIT_V   = 3'd3,
        S_REQ_M    = 3'd4,
        S_WAIT_M   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                r_state;
    logic [WAIT_W-1:0]     r_wait;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [15:0]           r_remaining;
    logic [CRED_W-1:0]     r_outstanding;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [3:0][31:0]      r_vertex;
    logic                  r_vvalid;
    logic [11:0]           r_material;
    logic                  r_mvalid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic w_credit_ok;
    logic w_wait_last;
    logic w_last_rec;
    logic w_stop;
    logic w_reserve;

    assign w_credit_ok = (r_outstanding < CRED_MAX);
    assign w_wait_last = (r_wait == WAIT_LAST);
    assign w_last_rec  = (r_remaining == 16'd1);

`ifdef STREAMER_ABORT_EN
    logic r_abort_pending;
    assign w_stop = r_abort_pending || bus.abort_in;
`else
    assign w_stop = 1'b0;
`endif

    // A reservation is taken on exactly the transitions that enter REQ_V.
    always_comb begin
        w_reserve = 1'b0;
        case (r_state)
            S_IDLE:     w_reserve = bus.start_in && (bus.tri_count_in != 16'd0) && w_credit_ok;
            S_PRECHECK: w_reserve = w_credit_ok && !w_stop;
            S_WAIT_M:   w_reserve = w_wait_last && !w_last_rec && !w_stop && w_credit_ok;
            default:    w_reserve = 1'b0;
        endcase
    end

    // The FIFO write strobes have no ready: capacity is guaranteed by credits,
    // one credit per record, returned by one consumed_in pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_outstanding <= '0;
            r_error       <= 1'b0;
        end else if (w_reserve && !bus.consumed_in) begin
            r_outstanding <= r_outstanding + CRED_ONE;
        end else if (!w_reserve && bus.consumed_in) begin
            if (r_outstanding == '0) begin
                r_error <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding - CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_rom_addr  <= '0;
            r_vertex    <= '0;
            r_vvalid    <= 1'b0;
            r_material  <= '0;
            r_mvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vvalid <= 1'b0;
            r_mvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        r_ptr       <= bus.base_addr_in;
                        r_remaining <= bus.tri_count_in;
                        if (bus.tri_count_in == 16'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy <= 1'b1;
                            if (w_reserve) begin
                                r_rom_addr <= bus.base_addr_in;
                                r_state    <= S_REQ_V;
                            end else begin
                                r_state <= S_PRECHECK;
                            end
                        end
                    end
                end
                S_PRECHECK: begin
                    if (w_stop) begin
                        r_state <= S_DONE;
                    end else if (w_reserve) begin
                        r_rom_addr <= r_ptr;
                        r_state    <= S_REQ_V;
                    end
                end
                S_REQ_V: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT_V;
                end
                S_WAIT_V: begin
                    if (w_wait_last) begin
                        r_vertex   <= bus.rom_data_in;
                        r_vvalid   <= 1'b1;
                        r_rom_addr <= r_ptr + ADDR_ONE;
                        r_state    <= S_REQ_M;
                    end else begin
                        r_wait <= r_wait + WAIT_ONE;
                    end
                end
                S_REQ_M: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT_M;
                end
                S_WAIT_M: begin
                    if (w_wait_last) begin
                        r_material  <= bus.rom_data_in[11:0];
                        r_mvalid    <= 1'b1;
                        r_remaining <= r_remaining - 16'd1;
                        r_ptr       <= r_ptr + ADDR_TWO;
                        if (w_last_rec || w_stop) begin
                            r_state <= S_DONE;
                        end else if (w_reserve) begin
                            r_rom_addr <= r_ptr + ADDR_TWO;
                            r_state    <= S_REQ_V;
                        end else begin
                            r_state <= S_PRECHECK;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_ONE;
                    end
                end
                S_DONE: begin
                    // A zero-count start already pulsed done on entry; every
                    // other path arrives with done low and pulses it here.
                    r_done  <= !r_done;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STREAMER_ABORT_EN
    // Once a record holds a credit it runs to completion; the abort is parked here.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_abort_pending <= 1'b0;
        end else if (r_state == S_IDLE || r_state == S_DONE) begin
            r_abort_pending <= 1'b0;
        end else if (bus.abort_in) begin
            r_abort_pending <= 1'b1;
        end
    end
`endif

    assign bus.rom_addr_out       = r_rom_addr;
    assign bus.vertex_valid_out   = r_vvalid;
    assign bus.vertex_out         = r_vertex;
    assign bus.material_valid_out = r_mvalid;
    assign bus.material_out       = r_material;
    assign bus.busy_out           = r_busy;
    assign bus.done_out           = r_done;
    assign bus.error_out          = r_error;
    assign bus.dbg_state          = r_state;
endmodule

// File: tb/tb_model_streamer.sv
// Bench for model_streamer (ROM_LATENCY=2, FIFO_DEPTH=4) with a two-stage ROM model;
// the abort sequence is compiled in when STREAMER_ABORT_EN is defined.
module tb_model_streamer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    model_streamer_if #(.ADDR_WIDTH(16)) bus ();

    model_streamer #(
        .ADDR_WIDTH (16),
        .ROM_LATENCY(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rom_word(input logic [15:0] a);
        return {16'hA5A5, a, 16'h1357, ~a, 16'h2468, a ^ 16'h0F0F, a + 16'h0101, a ^ 16'h5A5A};
    endfunction

    logic [127:0] rom_d1;
    always @(posedge clk) begin
        rom_d1          <= rom_word(bus.rom_addr_out);
        bus.rom_data_in <= rom_d1;
    end

    // Event monitor: every strobe, done pulse and ROM address change, stamped with cycle.
    int           v_cyc[$];
    logic [127:0] v_dat[$];
    int           m_cyc[$];
    logic [11:0]  m_dat[$];
    int           d_cyc[$];
    logic [15:0]  a_q[$];
    logic [15:0]  prev_addr = 16'h0;
    always @(negedge clk) begin
        if (bus.vertex_valid_out) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(bus.vertex_out);
        end
        if (bus.material_valid_out) begin
            m_cyc.push_back(cyc);
            m_dat.push_back(bus.material_out);
        end
        if (bus.done_out) d_cyc.push_back(cyc);
        if (bus.rom_addr_out != prev_addr) a_q.push_back(bus.rom_addr_out);
        prev_addr = bus.rom_addr_out;
    end

    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        int          restart_at;
        int          exp_recs;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input bit with_reset);
        int t0, vi0, mi0, di0, ai0;
        logic busy1;
        logic [15:0] a;
        if (with_reset) do_reset();
        vi0 = v_cyc.size();
        mi0 = m_cyc.size();
        di0 = d_cyc.size();
        ai0 = a_q.size();
        busy1 = 1'b0;
        bus.base_addr_in = v.base;
        bus.tri_count_in = v.count;
        bus.start_in = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start_in = 1'b0;
            if (k == v.restart_at) begin
                bus.start_in = 1'b1;
                bus.base_addr_in = 16'h7777;
                bus.tri_count_in = 16'd5;
            end
            if (k == 1) busy1 = bus.busy_out;
        end
        check("busy_after_start", busy1, (v.exp_recs > 0) ? 1 : 0);
        check("vertex_strobes", v_cyc.size() - vi0, v.exp_recs);
        check("material_strobes", m_cyc.size() - mi0, v.exp_recs);
        check("done_pulses", d_cyc.size() - di0, 1);
        if (d_cyc.size() > di0) check("done_time", d_cyc[di0] - t0, v.exp_done);
        for (int k = 0; k < v.exp_recs; k++) begin
            a = v.base + 16'(2 * k);
            if (v_cyc.size() > vi0 + k) begin
                check("vertex_time", v_cyc[vi0 + k] - t0, 4 + 6 * k);
                check("vertex_data", v_dat[vi0 + k], rom_word(a));
            end
            if (m_cyc.size() > mi0 + k) begin
                check("material_time", m_cyc[mi0 + k] - t0, 7 + 6 * k);
                check("material_data", m_dat[mi0 + k], rom_word(a + 16'd1) & 128'hFFF);
            end
        end
        exp_q = {};
        for (int k = 0; k < v.exp_recs; k++) begin
            exp_q.push_back(v.base + 16'(2 * k));
            exp_q.push_back(v.base + 16'(2 * k + 1));
        end
        check("addr_changes", a_q.size() - ai0, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            if (a_q.size() > ai0 + j) check("addr_seq", a_q[ai0 + j], exp_q[j]);
        end
        check("busy_at_end", bus.busy_out, 0);
        check("error_at_end", bus.error_out, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int t0, c, vi0, mi0, di0;
        bus.start_in = 1'b0;
        bus.base_addr_in = 16'h0;
        bus.tri_count_in = 16'h0;
        bus.consumed_in = 1'b0;
`ifdef STREAMER_ABORT_EN
        bus.abort_in = 1'b0;
`endif
        rst = 1'b0;

        vecs[0] = '{16'h0010, 16'd1, 0, 1, 8};
        vecs[1] = '{16'hFFFE, 16'd3, 0, 3, 20};
        vecs[2] = '{16'h1234, 16'd2, 5, 2, 14};
        vecs[3] = '{16'h0050, 16'd0, 1, 0, 1};

        do_reset();
        check("rst_vertex_valid", bus.vertex_valid_out, 0);
        check("rst_material_valid", bus.material_valid_out, 0);
        check("rst_busy", bus.busy_out, 0);
        check("rst_done", bus.done_out, 0);
        check("rst_error", bus.error_out, 0);
        check("rst_rom_addr", bus.rom_addr_out, 0);
        check("rst_vertex", bus.vertex_out, 0);
        check("rst_material", bus.material_out, 0);
        check("rst_state", bus.dbg_state, 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b1);

        // Credit limit: FIFO_DEPTH=4 allows 3 records, then one per consume pulse.
        do_reset();
        vi0 = v_cyc.size();
        mi0 = m_cyc.size();
        di0 = d_cyc.size();
        bus.base_addr_in = 16'h0100;
        bus.tri_count_in = 16'd10;
        bus.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("stall_vertex_count", v_cyc.size() - vi0, 3);
        check("stall_material_count", m_cyc.size() - mi0, 3);
        check("stall_busy", bus.busy_out, 1);
        check("stall_no_done", d_cyc.size() - di0, 0);
        bus.consumed_in = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        bus.consumed_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("release_vertex_count", v_cyc.size() - vi0, 4);
        check("release_material_count", m_cyc.size() - mi0, 4);
        check("release_busy", bus.busy_out, 1);
        if (v_cyc.size() > vi0 + 3) begin
            check("release_vertex_time", v_cyc[vi0 + 3] - c, 5);
            check("release_vertex_data", v_dat[vi0 + 3], rom_word(16'h0106));
        end
        if (m_dat.size() > mi0 + 3)
            check("release_material_data", m_dat[mi0 + 3], rom_word(16'h0107) & 128'hFFF);
        check("release_no_error", bus.error_out, 0);

        // Consume with nothing outstanding is an error that sticks until reset.
        do_reset();
        bus.consumed_in = 1'b1;
        check("err_before_edge", bus.error_out, 0);
        @(posedge clk);
        #1;
        bus.consumed_in = 1'b0;
        check("err_set", bus.error_out, 1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", bus.error_out, 1);
        do_reset();
        check("err_cleared", bus.error_out, 0);

        // Reset the cycle after the first vertex strobe abandons the record.
        vi0 = v_cyc.size();
        mi0 = m_cyc.size();
        bus.base_addr_in = 16'h0200;
        bus.tri_count_in = 16'd3;
        bus.start_in = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            bus.start_in = 1'b0;
            if (k == 5) rst = 1'b0;
            if (k == 8) rst = 1'b1;
            if (k == 6) begin
                check("mid_vertex_seen", v_cyc.size() - vi0, 1);
                check("mid_rst_vertex_valid", bus.vertex_valid_out, 0);
                check("mid_rst_material_valid", bus.material_valid_out, 0);
                check("mid_rst_busy", bus.busy_out, 0);
                check("mid_rst_done", bus.done_out, 0);
                check("mid_rst_rom_addr", bus.rom_addr_out, 0);
                check("mid_rst_vertex", bus.vertex_out, 0);
                check("mid_rst_material", bus.material_out, 0);
            end
        end
        check("mid_no_material", m_cyc.size() - mi0, 0);
        run_vec('{16'h0300, 16'd1, 0, 1, 8}, 1'b0);

`ifdef STREAMER_ABORT_EN
        // Abort in WAIT_V of record 2 of 5: record 2 still completes, then done.
        do_reset();
        vi0 = v_cyc.size();
        mi0 = m_cyc.size();
        di0 = d_cyc.size();
        bus.base_addr_in = 16'h0400;
        bus.tri_count_in = 16'd5;
        bus.start_in = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start_in = 1'b0;
            bus.abort_in = (k == 8);
        end
        check("abort_vertex_count", v_cyc.size() - vi0, 2);
        check("abort_material_count", m_cyc.size() - mi0, 2);
        check("abort_done_count", d_cyc.size() - di0, 1);
        if (d_cyc.size() > di0) check("abort_done_time", d_cyc[di0] - t0, 14);
        if (m_cyc.size() > mi0 + 1) begin
            check("abort_material2_time", m_cyc[mi0 + 1] - t0, 13);
            check("abort_material2_data", m_dat[mi0 + 1], rom_word(16'h0403) & 128'hFFF);
        end
        check("abort_busy_end", bus.busy_out, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
